rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
Round-robin arbiter and select sequencer for a shared 32:1 single-bit mux. Up to N requesters compete for the mux. The block grants one requester at a time, drives the mux select, and returns the selected data bit registered. It also enforces a maximum hold time so that no single requester can starve the others.

Parameters:
N, 32, number of requesters / mux inputs (2..32)
SELW, 5, select width; must equal ceil(log2(N))
HOLD_MAX, 16, max grant length in cycles (1..65535); 0 = unlimited hold

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req  in  N  per-requester request, level-sensitive
done  in  1  current owner releases grant (single-cycle pulse, sampled only while busy)
data  in  N  mux data inputs, bit i belongs to requester i
grant  out  N  one-hot grant, all-zero when idle
sel  out  SELW  mux select = index of current/last owner
busy  out  1  1 while a grant is active
out  out  1  registered data[sel] of current owner; 0 when idle
expired  out  1  one-cycle pulse when a grant is revoked by hold timeout

Behaviour:
- Reset (async, rst=1): state IDLE, grant=0, sel=0, busy=0, out=0, expired=0, hold counter=0. Last-owner pointer = N-1, so the first search starts at index 0.
- FSM states:
  - IDLE, no grant.
  - GRANT, one owner.
- IDLE -> GRANT when |req=1:
  - Winner = first i with req[i]=1, scanning (last+1) mod N upward and wrapping through N-1 to 0.
  - Registered on that edge: grant[winner]=1, sel=winner, busy=1, counter=0.
  - Latency: req asserted at edge k -> grant visible after edge k+1.
- GRANT, every cycle:
  - out <= data[sel], which is 1 cycle behind data.
  - counter increments; it saturates, never wraps.
- GRANT -> IDLE when any release condition holds:
  - (a) done=1
  - (b) req[sel]=0
  - (c) HOLD_MAX!=0 and counter==HOLD_MAX-1, i.e. the grant has lasted HOLD_MAX cycles
- On release, registered:
  - grant=0, busy=0, out=0, last<=sel.
  - sel holds its value; it is not cleared.
  - expired=1 for one cycle only if (c) applies and neither (a) nor (b) does.
- Mandatory one idle cycle between consecutive grants, even if req is held. Re-arbitration happens in that IDLE cycle using the updated last pointer.
- Simultaneous done and timeout: treated as a normal release, expired=0.
- A requester dropping req while not granted has no effect. Requests are never latched; only the level at the arbitration edge counts.
- Wrap: with last=N-1 the search starts at 0. If only the last owner requests, it wins again.
- HOLD_MAX=1: every grant lasts exactly 1 cycle.
- HOLD_MAX=0: the counter is ignored and expired is never asserted.
- done while IDLE: ignored.
- Reset mid-grant: all outputs return to reset values immediately, asynchronously. The pointer returns to N-1.
- Invariants, every cycle:
  - grant is one-hot or zero.
  - busy == |grant.
  - When busy=1, grant[sel]=1.

Test Plan:
- Reset then req=32'h0000_0001, held, HOLD_MAX=16 -> grant=0x1, sel=0, busy=1 one cycle after req. Released after 16 cycles with expired=1 pulse. One idle cycle, then regranted to 0.
- req=32'h8000_0011 held, done pulsed 3 cycles into each grant -> grant order 0, 4, 31, 0. Exactly one idle cycle between grants. sel follows 0, 4, 31, 0.
- Grant to 5 active, data[5] toggles 1,0,1 -> out shows 1,0,1 delayed one cycle. out=0 in the cycle after release.
- Owner 7 drops req[7] mid-grant with HOLD_MAX=0 -> busy=0 next edge, expired=0, last=7. Pending req[3] alone is granted next (wrap from 8..31 to 3).
- done and timeout in the same cycle (HOLD_MAX=4, done at 4th cycle) -> release, expired=0.
- rst asserted between clock edges while sel=12, busy=1 -> grant=0, busy=0, out=0, sel=0 immediately. After rst drops with req=0x1001, grant goes to 0 first.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - request/grant/mux bundle shared by rr_mux_arbiter and its requesters
interface rr_mux_arbiter_if #(
   parameter int N    = 32,
   parameter int SELW = 5
);
   logic [N-1:0]    req;
   logic            done;
   logic [N-1:0]    data;
   logic [N-1:0]    grant;
   logic [SELW-1:0] sel;
   logic            busy;
   logic            out;
   logic            expired;

   modport master (
      output req, done, data,
      input  grant, sel, busy, out, expired
   );

   modport slave (
      input  req, done, data,
      output grant, sel, busy, out, expired
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving a shared N:1 mux select with hold-time limit
module rr_mux_arbiter #(
   parameter int N        = 32,
   parameter int SELW     = 5,
   parameter int HOLD_MAX = 16
) (
   input  logic            clk,
   input  logic            rst,
   rr_mux_arbiter_if.slave bus
);
   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   // Counter value seen in the last permitted cycle; meaningless when HOLD_MAX is 0.
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

   state_t          state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [SELW-1:0] last_q, last_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            out_q, out_d;
   logic            expired_q, expired_d;

   logic [SELW-1:0] scan_idx;
   logic [SELW-1:0] win_idx;
   logic            win_found;
   logic            rel_done;
   logic            rel_drop;
   logic            rel_time;

   // Scan starts one past the last owner so the last owner is considered last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= N; k++) begin
         scan_idx = SELW'((int'(last_q) + k) % N);
         if (!win_found && bus.req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      out_d     = 1'b0;
      expired_d = 1'b0;
      rel_done  = bus.done;
      rel_drop  = !bus.req[sel_q];
      rel_time  = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d = ST_GRANT;
               grant_d = N'(1) << win_idx;
               sel_d   = win_idx;
               cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (rel_done || rel_drop || rel_time) begin
               state_d   = ST_IDLE;
               grant_d   = '0;
               last_d    = sel_q;
               expired_d = rel_time && !rel_done && !rel_drop;
            end else begin
               out_d = bus.data[sel_q];
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         sel_q     <= '0;
         last_q    <= SELW'(N - 1);
         cnt_q     <= '0;
         out_q     <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         expired_q <= expired_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = (state_q == ST_GRANT);
   assign bus.out     = out_q;
   assign bus.expired = expired_q;
endmodule
